ftoi_sched: RTL and testbench

- Shares one combinational `ftoi` core (fp32 to int32) between N_REQ requesters, e.g. the FPU issue ports.
- Round-robin arbitration with per-requester valid/ready on request and response.
- A LAT-stage pipeline carries the operand, requester ID and valid bit around the core.
- Per-requester result FIFOs with credit-based admission, so a stalled consumer never blocks the other requesters.

---
 rtl/ftoi_sched.sv | 208 ++++++++++++++++++++
 tb/tb_ftoi_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ftoi_sched.sv
// rtl/ftoi_sched.sv - round-robin shared fp32->int32 converter with credit-gated per-requester result FIFOs
// Optional: define FTOI_SCHED_SAT_EN to saturate out-of-range results to int32 min/max.
module ftoi_sched #(
    parameter int N_REQ = 2,
    parameter int LAT   = 2,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    resp_valid,
    input  logic [N_REQ-1:0]    resp_ready,
    output logic [32*N_REQ-1:0] resp_data,
    output logic                busy
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Truncating conversion; exponents at or above 158 wrap (unspecified range).
    function automatic logic [31:0] f_ftoi(input logic [31:0] f);
        logic [31:0] mag;
        mag = {8'd0, 1'b1, f[22:0]};
        if (f[30:23] < 8'd127)
            mag = '0;
        else if (f[30:23] >= 8'd150)
            mag = mag << (f[30:23] - 8'd150);
        else
            mag = mag >> (8'd150 - f[30:23]);
        return f[31] ? (~mag + 32'd1) : mag;
    endfunction

    logic             r_live;
    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_credit [N_REQ];
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_grant;
    logic [N_REQ-1:0] w_pop;
    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_gnt_any;
    logic [31:0]      w_op;

    always_comb begin
        w_elig    = '0;
        w_grant   = '0;
        w_gnt_id  = r_ptr;
        w_gnt_any = 1'b0;
        w_idx     = '0;
        w_op      = '0;
        for (int i = 0; i < N_REQ; i++)
            w_elig[i] = req_valid[i] && (r_credit[i] != '0);
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % N_REQ);
            if (r_live && !w_gnt_any && w_elig[w_idx]) begin
                w_gnt_any      = 1'b1;
                w_gnt_id       = w_idx;
                w_grant[w_idx] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++)
            if (w_grant[i]) w_op = req_data[32*i +: 32];
    end

    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_live <= 1'b0;
            r_ptr  <= IDW'(N_REQ - 1);
        end else begin
            r_live <= 1'b1;
            if (w_gnt_any) r_ptr <= w_gnt_id;
        end
    end

    logic           r_s1_vld;
    logic [IDW-1:0] r_s1_id;
    logic [31:0]    r_s1_op;
    logic [31:0]    w_core;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld <= 1'b0;
            r_s1_id  <= '0;
            r_s1_op  <= '0;
        end else begin
            r_s1_vld <= w_gnt_any;
            if (w_gnt_any) begin
                r_s1_id <= w_gnt_id;
                r_s1_op <= w_op;
            end
        end
    end

    always_comb begin
        w_core = f_ftoi(r_s1_op);
`ifdef FTOI_SCHED_SAT_EN
        if (r_s1_op[30:23] >= 8'd158)
            w_core = r_s1_op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    end

    logic           w_wr_vld;
    logic [IDW-1:0] w_wr_id;
    logic [31:0]    w_wr_data;
    logic           w_tail_busy;

    generate
        if (LAT == 1) begin : g_lat1
            assign w_wr_vld    = r_s1_vld;
            assign w_wr_id     = r_s1_id;
            assign w_wr_data   = w_core;
            assign w_tail_busy = 1'b0;
        end else begin : g_latn
            logic           r_t_vld [LAT-1];
            logic [IDW-1:0] r_t_id  [LAT-1];
            logic [31:0]    r_t_res [LAT-1];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < LAT-1; k++) begin
                        r_t_vld[k] <= 1'b0;
                        r_t_id[k]  <= '0;
                        r_t_res[k] <= '0;
                    end
                end else begin
                    r_t_vld[0] <= r_s1_vld;
                    r_t_id[0]  <= r_s1_id;
                    r_t_res[0] <= w_core;
                    for (int k = 1; k < LAT-1; k++) begin
                        r_t_vld[k] <= r_t_vld[k-1];
                        r_t_id[k]  <= r_t_id[k-1];
                        r_t_res[k] <= r_t_res[k-1];
                    end
                end
            end

            always_comb begin
                w_tail_busy = 1'b0;
                for (int k = 0; k < LAT-1; k++)
                    w_tail_busy = w_tail_busy | r_t_vld[k];
            end

            assign w_wr_vld  = r_t_vld[LAT-2];
            assign w_wr_id   = r_t_id[LAT-2];
            assign w_wr_data = r_t_res[LAT-2];
        end
    endgenerate

    logic [31:0]      r_mem  [N_REQ][DEPTH];
    logic [PW-1:0]    r_rptr [N_REQ];
    logic [PW-1:0]    r_wptr [N_REQ];
    logic [CW-1:0]    r_cnt  [N_REQ];
    logic [N_REQ-1:0] w_wr;

    always_comb begin
        w_wr       = '0;
        resp_valid = '0;
        resp_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_wr[i]               = w_wr_vld && (w_wr_id == IDW'(i));
            resp_valid[i]         = (r_cnt[i] != '0);
            resp_data[32*i +: 32] = r_mem[i][r_rptr[i]];
        end
    end

    assign w_pop = resp_valid & resp_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++)
            if (w_wr[i]) r_mem[i][r_wptr[i]] <= w_wr_data;
    end

    // Credits cover both in-flight ops and queued entries, so a write never finds its FIFO full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_rptr[i]   <= '0;
                r_wptr[i]   <= '0;
                r_cnt[i]    <= '0;
                r_credit[i] <= CW'(DEPTH);
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_wr[i])
                    r_wptr[i] <= (r_wptr[i] == PW'(DEPTH - 1)) ? '0 : r_wptr[i] + PW'(1);
                if (w_pop[i])
                    r_rptr[i] <= (r_rptr[i] == PW'(DEPTH - 1)) ? '0 : r_rptr[i] + PW'(1);
                case ({w_wr[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_credit[i] <= r_credit[i] - CW'(1);
                    2'b01:   r_credit[i] <= r_credit[i] + CW'(1);
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
        end
    end

    assign busy = r_s1_vld | w_tail_busy | (|resp_valid);

endmodule

// File: tb/tb_ftoi_sched.sv
// tb/tb_ftoi_sched.sv - directed self-checking bench for ftoi_sched (N_REQ=2, LAT=2, DEPTH=2)
module tb_ftoi_sched;
    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_data;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [63:0] resp_data;
    logic        busy;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ftoi_sched #(.N_REQ(2), .LAT(2), .DEPTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 2'b11; resp_ready = 2'b11; req_data = '0;
        @(negedge clk);
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tick();
        rstn = 1'b1; req_valid = 2'b00;
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_rdy [8];
        logic [1:0] exp_rv  [8];
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        exp_rv  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        req_data  = {32'h4B00_0000, 32'hC040_0000};
        req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++; if (req_ready !== exp_rdy[c]) begin n_err++; $display("FAIL contention_grant c%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
            n_vec++; if (resp_valid !== exp_rv[c]) begin n_err++; $display("FAIL contention_resp_valid c%0d: got %b expected %b", c, resp_valid, exp_rv[c]); end
            if (exp_rv[c][0]) begin
                n_vec++; if (resp_data[31:0] !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL contention_data0 c%0d: got %h expected fffffffd", c, resp_data[31:0]); end
            end
            if (exp_rv[c][1]) begin
                n_vec++; if (resp_data[63:32] !== 32'h0080_0000) begin n_err++; $display("FAIL contention_data1 c%0d: got %h expected 00800000", c, resp_data[63:32]); end
            end
            tick();
            if (c == 3) req_valid = 2'b00;
        end
    endtask

    task automatic test_single();
        req_data[31:0] = 32'h3F80_0000;
        req_valid = 2'b01;
        @(negedge clk);
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_accept: got %b expected 01", req_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_t0: got %b expected 0", busy); end
        tick();
        req_valid = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_vec++; if (busy !== (k <= 3)) begin n_err++; $display("FAIL single_busy t+%0d: got %b expected %b", k, busy, (k <= 3)); end
            n_vec++; if (resp_valid !== ((k == 3) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL single_resp_valid t+%0d: got %b", k, resp_valid); end
            if (k == 3) begin
                n_vec++; if (resp_data[31:0] !== 32'h0000_0001) begin n_err++; $display("FAIL single_data: got %h expected 00000001", resp_data[31:0]); end
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] ops     [3];
        logic [1:0]  exp_rdy [14];
        logic        exp_rv0 [14];
        logic [31:0] exp_d0  [14];
        logic        acc0;
        int          n0;
        ops     = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        exp_rdy = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        exp_rv0 = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
        exp_d0  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 0, 0, 3, 0};
        n0 = 0;
        resp_ready = 2'b10;
        req_data   = {32'h4B00_0000, ops[0]};
        req_valid  = 2'b11;
        for (int c = 0; c < 14; c++) begin
            if (c == 8) resp_ready = 2'b11;
            @(negedge clk);
            n_vec++; if (req_ready !== exp_rdy[c]) begin n_err++; $display("FAIL bp_grant c%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
            n_vec++; if (resp_valid[0] !== exp_rv0[c]) begin n_err++; $display("FAIL bp_resp_valid0 c%0d: got %b expected %b", c, resp_valid[0], exp_rv0[c]); end
            if (exp_rv0[c]) begin
                n_vec++; if (resp_data[31:0] !== exp_d0[c]) begin n_err++; $display("FAIL bp_data0 c%0d: got %h expected %h", c, resp_data[31:0], exp_d0[c]); end
            end
            acc0 = req_ready[0];
            tick();
            if (acc0) begin
                n0++;
                if (n0 < 3) req_data[31:0] = ops[n0];
            end
            if (n0 == 3) req_valid = 2'b00;
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] ops [6];
        logic        acc0;
        int          n_tx;
        int          n_rx;
        ops = '{32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};
        n_tx = 0; n_rx = 0;
        resp_ready = 2'b10;
        req_data[31:0] = ops[0];
        req_valid = 2'b01;
        for (int c = 0; c < 40; c++) begin
            if (c == 8) resp_ready = 2'b11;
            @(negedge clk);
            if (c == 7) begin
                n_vec++; if (req_ready[0] !== 1'b0) begin n_err++; $display("FAIL sim_full_stall: got %b expected 0", req_ready[0]); end
                n_vec++; if (resp_data[31:0] !== 32'd4) begin n_err++; $display("FAIL sim_full_head: got %h expected 00000004", resp_data[31:0]); end
            end
            if (resp_valid[0] && resp_ready[0]) begin
                n_vec++;
                if (n_rx >= 6) begin n_err++; $display("FAIL sim_extra_result: got %h expected none", resp_data[31:0]); end
                else if (resp_data[31:0] !== 32'(n_rx + 4)) begin n_err++; $display("FAIL sim_order #%0d: got %h expected %h", n_rx, resp_data[31:0], 32'(n_rx + 4)); end
                n_rx++;
            end
            acc0 = req_ready[0];
            tick();
            if (acc0) begin
                n_tx++;
                if (n_tx < 6) req_data[31:0] = ops[n_tx];
                else req_valid = 2'b00;
            end
        end
        n_vec++; if (n_rx != 6) begin n_err++; $display("FAIL sim_count: got %0d expected 6", n_rx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sim_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit found;
        resp_ready = 2'b00;
        req_data   = {32'h3F80_0000, 32'h4000_0000};
        req_valid  = 2'b10; tick();
        req_valid  = 2'b00; tick();
        req_valid  = 2'b01; tick();
        tick();
        req_valid  = 2'b00;
        #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre_busy: got %b expected 1", busy); end
        n_vec++; if (resp_valid !== 2'b10) begin n_err++; $display("FAIL rmid_pre_resp_valid: got %b expected 10", resp_valid); end
        rstn = 1'b0;
        req_valid = 2'b11;
        #1;
        n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL rmid_resp_valid: got %b expected 00", resp_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rmid_req_ready: got %b expected 00", req_ready); end
        tick();
        rstn = 1'b1;
        resp_ready = 2'b11;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL rmid_post_resp_valid: got %b expected 00", resp_valid); end
            end
            if (!found && req_ready !== 2'b00) begin
                found = 1'b1;
                n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmid_first_grant: got %b expected 01", req_ready); end
            end
            tick();
        end
        if (!found) begin n_vec++; n_err++; $display("FAIL rmid_first_grant: got no grant expected 01"); end
        req_valid = 2'b00;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_boundary();
        logic [31:0] vin  [9];
        logic [31:0] vexp [9];
        int          nb;
        bit          acc0;
        bit          ok;
        bit          got;
        vin  = '{32'h0000_0000, 32'h8000_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF,
                 32'h4F00_0000, 32'hCF00_0000, 32'h7F80_0000};
        vexp = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FF80, 32'h8000_0080,
                 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
`ifdef FTOI_SCHED_SAT_EN
        nb = 9;
`else
        nb = 6;
`endif
        resp_ready = 2'b11;
        for (int v = 0; v < nb; v++) begin
            req_data[31:0] = vin[v];
            req_valid = 2'b01;
            ok = 1'b0;
            for (int k = 0; k < 8 && !ok; k++) begin
                @(negedge clk);
                acc0 = req_ready[0];
                tick();
                if (acc0) ok = 1'b1;
            end
            req_valid = 2'b00;
            if (!ok) begin n_vec++; n_err++; $display("FAIL bnd_accept %h: got no accept expected accept", vin[v]); end
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                @(negedge clk);
                if (resp_valid[0]) begin
                    got = 1'b1;
                    n_vec++; if (resp_data[31:0] !== vexp[v]) begin n_err++; $display("FAIL bnd_result %h: got %h expected %h", vin[v], resp_data[31:0], vexp[v]); end
                end
                tick();
            end
            if (!got) begin n_vec++; n_err++; $display("FAIL bnd_result %h: got no result expected %h", vin[v], vexp[v]); end
        end
    endtask

    initial begin
        rstn = 1'b0; req_valid = '0; resp_ready = '0; req_data = '0;
        #2;
        test_reset();
        test_contention();
        test_single();
        test_back_pressure();
        test_simultaneous();
        test_reset_mid();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
